decode_stage: RTL
=================

Name: decode_stage

Overview:
Single-cycle MIPS decode stage sitting directly downstream of the fetch stage.
- Consumes the 32-bit instruction word (Inst) from fetch.
- Splits Inst into its fields and generates main control signals.
- Produces immediate and jump-target operands.
- Owns the 32x32 architectural register file: combinational reads, writes committed on the rising clock edge from the write-back path.

Parameters:
DATA_W, 32, register and datapath width
NREGS, 32, number of architectural registers
ADDR_W, 5, register index width (log2 NREGS)

Ports:
Clk  input  1  system clock; all register-file writes on rising edge
Reset  input  1  asynchronous, active-low reset
Inst  input  32  instruction word from fetch
RegWriteIn  input  1  write-back enable from the write-back mux
WriteReg  input  5  write-back destination index
WriteData  input  32  write-back data
ReadData1  output  32  register-file value at Inst[25:21] (rs)
ReadData2  output  32  register-file value at Inst[20:16] (rt)
ImmExt  output  32  extended Inst[15:0]
Rt, Rd  output  5 each  Inst[20:16], Inst[15:11], for the RegDst mux
Shamt  output  5  Inst[10:6]
Funct  output  6  Inst[5:0]
JumpTarget  output  26  Inst[25:0]
RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, Jump  output  1 each  main control
ALUOp  output  2  00 add, 01 sub, 10 R-type (use Funct), 11 or
Illegal  output  1  opcode not in the supported set

Behaviour:
Clock and reset
- Single clock, Clk. Reset is asynchronous and active-low: Reset=0 clears all NREGS registers to 0 immediately, without waiting for a clock edge.
- While Reset=0, all control outputs and Illegal are forced to 0, so the instruction behaves as a NOP and no memory or register writes occur.
- Field outputs (Rt, Rd, Shamt, Funct, JumpTarget) are pure wiring of Inst and are unaffected by reset.
- ReadData1 and ReadData2 read 0 during reset.

Register file
- Write: on the rising Clk edge, if Reset=1, RegWriteIn=1 and WriteReg!=0, then reg[WriteReg] <= WriteData.
- Register $0 always reads 0. A write to $0 is discarded.
- Reads are combinational from the stored array. There is no write-to-read bypass: a read during the same cycle as a write to the same index returns the old value until the edge.
- If Reset is asserted in the same cycle as a pending write, the write is lost and the array reads all zero.
- Reset deasserting near a clock edge: the write at that edge is either fully applied or not applied; partial-register corruption is not permitted.

Decode (combinational on Inst[31:26]; the sequential element is the register file)
- R-type, 0x00: RegDst=1, RegWrite=1, ALUOp=10.
- lw, 0x23: ALUSrc=1, MemToReg=1, RegWrite=1, MemRead=1, ALUOp=00; ImmExt sign-extended.
- sw, 0x2B: ALUSrc=1, MemWrite=1, ALUOp=00; ImmExt sign-extended.
- beq, 0x04: Branch=1, ALUOp=01; ImmExt sign-extended. Shift and PC add happen downstream.
- addi, 0x08: ALUSrc=1, RegWrite=1, ALUOp=00; ImmExt sign-extended.
- ori, 0x0D: ALUSrc=1, RegWrite=1, ALUOp=11; ImmExt zero-extended.
- j, 0x02: Jump=1; all other control signals 0.
- Any other opcode: all control signals 0, Illegal=1.
- For every opcode not listed above as zero-extended, ImmExt is sign-extended.
- Funct is not checked in this block. ALU control downstream owns illegal-Funct handling.

Decomposition:
- Shared package (mips_pkg) holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J;
  - ALUOp encodings;
  - DATA_W, ADDR_W.
- One sub-module: reg_file. It contains the 32x32 array, async active-low clear, $0 hardwiring, and two combinational read ports.
- decode_stage instantiates reg_file and contains the control decoder and the immediate extender.

Test Plan:
1. Reset=0 with Inst=0x01095020 -> ReadData1=ReadData2=0, all control signals 0, Illegal=0. Release Reset, then all regs read 0.
2. Inst=0x20080005 (addi $8,$0,5) -> ALUSrc=1, RegWrite=1, ALUOp=00, ImmExt=0x00000005. Next, write WriteReg=8, WriteData=5, RegWriteIn=1 for one edge -> ReadData1 with rs=8 shows 5 after the edge, not before.
3. Inst=0x8D09FFFC (lw $9,-4($8)) -> MemRead=1, MemToReg=1, ImmExt=0xFFFFFFFC. Inst=0x34088000 (ori) -> ImmExt=0x00008000, ALUOp=11.
4. Write WriteReg=0, WriteData=0xDEADBEEF -> with Inst=0x01095020 (rs=8, rt=9) applied, then Inst=0x00000020 (add $0,$0,$0; rs=rt=0), ReadData1 and ReadData2 read 0x00000000.
5. Inst=0x08000010 -> Jump=1, JumpTarget=0x0000010, RegWrite=0. Inst=0xFC000000 (opcode 0x3F) -> Illegal=1, all control signals 0.
6. Write regs 8 and 9 with 0x11111111 and 0x22222222. Pull Reset low asynchronously mid-cycle -> ReadData1 and ReadData2 go to 0 before the next edge. A write pending in that cycle is discarded.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: datapath sizes, opcodes, ALUOp encodings and the
// main-control bundle.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: async active-low clear, one write port on the rising
// clock edge, two combinational read ports, $0 hardwired to zero.
module reg_file
  import mips_pkg::*;
#(
  parameter int unsigned DataW = DATA_W,
  parameter int unsigned AddrW = ADDR_W,
  parameter int unsigned NRegs = NREGS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr1_i,
  input  logic [AddrW-1:0] raddr2_i,
  output logic [DataW-1:0] rdata1_o,
  output logic [DataW-1:0] rdata2_o
);

  logic [DataW-1:0] regs_q [NRegs];

  // Entry 0 is only ever cleared, so it always reads zero and writes to it are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NRegs); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // No write-to-read bypass: reads see the stored array only.
  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// Single-cycle MIPS decode: field split, main control, immediate extension and the
// register file.
module decode_stage
  import mips_pkg::*;
#(
  parameter int unsigned DataW = DATA_W,
  parameter int unsigned NRegs = NREGS,
  parameter int unsigned AddrW = ADDR_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      Inst,
  input  logic             RegWriteIn,
  input  logic [AddrW-1:0] WriteReg,
  input  logic [DataW-1:0] WriteData,
  output logic [DataW-1:0] ReadData1,
  output logic [DataW-1:0] ReadData2,
  output logic [DataW-1:0] ImmExt,
  output logic [4:0]       Rt,
  output logic [4:0]       Rd,
  output logic [4:0]       Shamt,
  output logic [5:0]       Funct,
  output logic [25:0]      JumpTarget,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             Jump,
  output logic [1:0]       ALUOp,
  output logic             Illegal
);

  logic [5:0] opcode;
  ctrl_t      ctrl;
  logic       illegal;

  assign opcode     = Inst[31:26];
  assign Rt         = Inst[20:16];
  assign Rd         = Inst[15:11];
  assign Shamt      = Inst[10:6];
  assign Funct      = Inst[5:0];
  assign JumpTarget = Inst[25:0];

  reg_file #(
    .DataW(DataW),
    .AddrW(AddrW),
    .NRegs(NRegs)
  ) u_reg_file (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .we_i    (RegWriteIn),
    .waddr_i (WriteReg),
    .wdata_i (WriteData),
    .raddr1_i(Inst[25:21]),
    .raddr2_i(Inst[20:16]),
    .rdata1_o(ReadData1),
    .rdata2_o(ReadData2)
  );

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_ORI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_OR;
      end
      OP_J:    ctrl.jump = 1'b1;
      default: illegal   = 1'b1;
    endcase
    // Held in reset the instruction behaves as a NOP.
    if (!Reset) begin
      ctrl    = '0;
      illegal = 1'b0;
    end
  end

  assign RegDst   = ctrl.reg_dst;
  assign ALUSrc   = ctrl.alu_src;
  assign MemToReg = ctrl.mem_to_reg;
  assign RegWrite = ctrl.reg_write;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign Branch   = ctrl.branch;
  assign Jump     = ctrl.jump;
  assign ALUOp    = ctrl.alu_op;
  assign Illegal  = illegal;

  assign ImmExt = (opcode == OP_ORI) ? {{(DataW-16){1'b0}}, Inst[15:0]}
                                     : {{(DataW-16){Inst[15]}}, Inst[15:0]};

endmodule
